// File: rtl/data_responder_if.sv
// Bus signals between an initiator and data_responder.
// Signal names keep the device-side _i/_o suffixes on both modports.
interface data_responder_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic              data_cyc_i;
    logic              data_stb_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_adr_i;
    logic [DATA_W-1:0] data_dat_i;
    logic [DATA_W-1:0] data_dat_o;
    logic              data_ack_o;

    modport master (
        output data_cyc_i, data_stb_i, data_we_i, data_adr_i, data_dat_i,
        input  data_dat_o, data_ack_o
    );

    modport slave (
        input  data_cyc_i, data_stb_i, data_we_i, data_adr_i, data_dat_i,
        output data_dat_o, data_ack_o
    );
endinterface

// File: rtl/data_responder.sv
// Single-port register-file responder with a fixed number of wait states before ack.
// Requests are latched in IDLE; writes commit at the end of the ACK cycle.
module data_responder #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    data_responder_if.slave   bus,
    output logic              busy_o
);
    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdat_q;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] mem_q [Depth];

    logic              latch;
    logic              mem_we;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_adr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        mem_we  = 1'b0;
        rd_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.data_cyc_i && bus.data_stb_i) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                        rd_load = !bus.data_we_i;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                // Only cyc aborts; a dropped stb alone keeps the transfer alive.
                if (!bus.data_cyc_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    rd_load = !we_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
                mem_we  = we_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // In IDLE the request is not latched yet, so read straight from the bus.
    assign rd_adr = (state_q == StIdle) ? bus.data_adr_i : adr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                adr_q  <= bus.data_adr_i;
                we_q   <= bus.data_we_i;
                wdat_q <= bus.data_dat_i;
            end
            if (rd_load) begin
                dat_q <= mem_q[rd_adr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[adr_q] <= wdat_q;
        end
    end

    assign bus.data_dat_o = dat_q;
    assign bus.data_ack_o = (state_q == StAck);
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_data_responder.sv
// Directed bench for data_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_responder;
    logic clk;
    logic rst;
    logic busy;
    logic busy0;
    int   checks;
    int   errors;

    data_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();
    data_responder_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();

    data_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .busy_o (busy)
    );

    data_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus0.slave),
        .busy_o (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic cyc, input logic stb, input logic we,
                           input logic [3:0] adr, input logic [7:0] dat);
        bus.data_cyc_i = cyc;
        bus.data_stb_i = stb;
        bus.data_we_i  = we;
        bus.data_adr_i = adr;
        bus.data_dat_i = dat;
    endtask

    // Full read on the WAIT_CYCLES=2 instance; ack must land in cycle 3.
    task automatic do_read(input logic [3:0] adr, input logic [7:0] exp, input string tag);
        int c;
        c = 0;
        set_req(1'b1, 1'b1, 1'b0, adr, 8'h00);
        do begin
            tick();
            c++;
        end while (!bus.data_ack_o && c < 8);
        check({tag, "_lat"}, c, 3);
        check({tag, "_dat"}, {24'd0, bus.data_dat_o}, {24'd0, exp});
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
    endtask

    initial begin
        int ack_cyc[2];
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        bus0.data_cyc_i = 1'b0;
        bus0.data_stb_i = 1'b0;
        bus0.data_we_i  = 1'b0;
        bus0.data_adr_i = 4'h0;
        bus0.data_dat_i = 8'h00;

        #3;
        check("rst_ack", bus.data_ack_o, 0);
        check("rst_busy", busy, 0);
        check("rst_dat", bus.data_dat_o, 0);
        check("rst_busy0", busy0, 0);
        #9 rst = 1'b0;

        do_read(4'd7, 8'h00, "rd7_after_rst");

        // Write A5 to 3; inputs change after sampling and cyc drops in the ACK cycle.
        set_req(1'b1, 1'b1, 1'b1, 4'd3, 8'hA5);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("wr3_ack_c%0d", c), bus.data_ack_o, (c == 3));
            check($sformatf("wr3_busy_c%0d", c), busy, (c <= 3));
            if (c == 1) set_req(1'b1, 1'b0, 1'b0, 4'hF, 8'hFF);
            if (c == 3) set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
        do_read(4'd3, 8'hA5, "rd3");
        tick();
        check("hold_dat", bus.data_dat_o, 8'hA5);

        // cyc low with stb high is not a request.
        set_req(1'b0, 1'b1, 1'b1, 4'd3, 8'h77);
        tick();
        check("stb_only_busy", busy, 0);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();

        // Abort: cyc drops in the first WAIT cycle.
        set_req(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C);
        tick();
        check("abort_wait_busy", busy, 1);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        check("abort_busy", busy, 0);
        check("abort_ack", bus.data_ack_o, 0);
        tick();
        check("abort_ack2", bus.data_ack_o, 0);
        do_read(4'd5, 8'h00, "rd5_abort");

        // Back-to-back writes with cyc/stb held high throughout.
        n = 0;
        ack_cyc[0] = 0;
        ack_cyc[1] = 0;
        set_req(1'b1, 1'b1, 1'b1, 4'd1, 8'h11);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.data_ack_o) begin
                ack_cyc[n] = c;
                n++;
                if (n == 1) set_req(1'b1, 1'b1, 1'b1, 4'd2, 8'h22);
                else        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            end
            if (n == 2) break;
        end
        check("b2b_n_acks", n, 2);
        check("b2b_ack1", ack_cyc[0], 3);
        check("b2b_ack2", ack_cyc[1], 7);
        tick();
        do_read(4'd1, 8'h11, "rd1");
        do_read(4'd2, 8'h22, "rd2");

        // WAIT_CYCLES=0 instance: ack in the cycle right after sampling.
        bus0.data_cyc_i = 1'b1;
        bus0.data_stb_i = 1'b1;
        bus0.data_we_i  = 1'b1;
        bus0.data_adr_i = 4'd4;
        bus0.data_dat_i = 8'h5A;
        tick();
        check("w0_wr_ack", bus0.data_ack_o, 1);
        check("w0_wr_busy", busy0, 1);
        bus0.data_cyc_i = 1'b0;
        bus0.data_stb_i = 1'b0;
        tick();
        check("w0_idle_ack", bus0.data_ack_o, 0);
        check("w0_idle_busy", busy0, 0);
        bus0.data_cyc_i = 1'b1;
        bus0.data_stb_i = 1'b1;
        bus0.data_we_i  = 1'b0;
        tick();
        check("w0_rd_ack", bus0.data_ack_o, 1);
        check("w0_rd_dat", bus0.data_dat_o, 8'h5A);
        bus0.data_cyc_i = 1'b0;
        bus0.data_stb_i = 1'b0;
        tick();

        // Asynchronous reset in the middle of a WAIT for a write to 9.
        set_req(1'b1, 1'b1, 1'b1, 4'd9, 8'h99);
        tick();
        check("arst_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ack", bus.data_ack_o, 0);
        check("arst_dat", bus.data_dat_o, 0);
        check("arst_dat0", bus0.data_dat_o, 0);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        rst = 1'b0;
        tick();
        check("arst_post_ack", bus.data_ack_o, 0);
        do_read(4'd9, 8'h00, "rd9_arst");
        do_read(4'd3, 8'h00, "rd3_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_responder.md
DATA_RESPONDER -- requirements
Module: data_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning word-address width (depth = 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before ack (legal range 0-15).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port data_cyc_i  input  1  bus cycle active from the initiator.
REQ-007 SHALL have port data_stb_i  input  1  transfer strobe from the initiator.
REQ-008 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port data_adr_i  input  ADDR_W  word address.
REQ-010 SHALL have port data_dat_i  input  DATA_W  write data.
REQ-011 SHALL have port data_dat_o  output  DATA_W  read data, registered.
REQ-012 SHALL have port data_ack_o  output  1  transfer acknowledge, one-cycle pulse.
REQ-013 SHALL have port busy_o  output  1  high whenever the state machine is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-015 In IDLE, a request SHALL be data_cyc_i & data_stb_i sampled high at a rising edge; it latches address, we and write data and moves to WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0).
REQ-016 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry, decrement each cycle, and move to ACK at the edge where the counter is 0.
REQ-017 data_ack_o SHALL be high exactly during the ACK state cycle, i.e. in cycle WAIT_CYCLES+1 counting the request-sample cycle as cycle 0.
REQ-018 A write SHALL commit the latched data to the latched address at the edge that ends the ACK cycle; no earlier.
REQ-019 A read SHALL drive data_dat_o with mem[latched address] during the ACK cycle; data_dat_o SHALL hold its last value otherwise.
REQ-020 Latched address/data/we SHALL not change while in WAIT or ACK, regardless of input changes.
REQ-021 From ACK the FSM SHALL return to IDLE; if data_cyc_i & data_stb_i are high at that same edge, the FSM SHALL NOT start a new transfer then (one IDLE cycle minimum between transfers).
REQ-022 If data_cyc_i is low at any edge while in WAIT, the transfer SHALL abort: return to IDLE, no ack, no write.
REQ-023 data_cyc_i low during the ACK cycle SHALL NOT suppress the ack or the write (ack already committed).
REQ-024 data_stb_i deasserting while data_cyc_i stays high in WAIT SHALL NOT abort the transfer.
REQ-025 Requests with data_cyc_i low and data_stb_i high SHALL be ignored.
REQ-026 Address range SHALL be the full 2**ADDR_W space; no error response exists.

Reset
REQ-027 Asserting rst SHALL immediately force state IDLE, data_ack_o=0, busy_o=0, data_dat_o=0, counter=0, and all memory words to 0.
REQ-028 rst asserted mid-transfer SHALL cancel it with no write and no ack; first request is accepted at the first rising edge after rst deasserts.

Verification
REQ-029 Reset, then write 8'hA5 to address 3 with WAIT_CYCLES=2 -> ack high in cycle 3 only, busy_o high cycles 1-3; subsequent read of address 3 returns 8'hA5 with its ack.
REQ-030 Read address 7 after reset -> data_dat_o = 8'h00 during ack cycle.
REQ-031 Write 8'h3C to address 5, drop data_cyc_i during first WAIT cycle -> no ack, FSM IDLE next cycle, read of address 5 returns 8'h00.
REQ-032 Initiator holds cyc/stb high across two back-to-back writes (addr 1 = 8'h11, addr 2 = 8'h22) -> two acks separated by exactly WAIT_CYCLES+1 cycles plus one IDLE cycle; both values read back.
REQ-033 WAIT_CYCLES=0 build: read request -> ack in the cycle immediately after sampling.
REQ-034 Assert rst asynchronously (between edges) during WAIT of a write to address 9 -> outputs zero at once, no ack, address 9 reads 8'h00 afterwards.
